// File: rtl/five12_pkg.sv
// Shared definitions for the move command path and the game-state stage.
// Contents:
//   DIR_R/L/U/D - 2-bit move direction codes
//   state_t     - move_cmd_gen handshake FSM states
//   prio_dir()  - fixed-priority encode R > L > U > D of a {D,U,L,R} vector
package five12_pkg;

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_L = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PEND     = 2'b01,
        WAIT_REL = 2'b10
    } state_t;

    // Bit order of btns is {D,U,L,R}; the lowest set bit wins.
    function automatic logic [1:0] prio_dir(input logic [3:0] btns);
        logic [1:0] dir;
        dir = DIR_D;
        if (btns[0]) begin
            dir = DIR_R;
        end else if (btns[1]) begin
            dir = DIR_L;
        end else if (btns[2]) begin
            dir = DIR_U;
        end
        return dir;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser plus debouncer for one raw pushbutton.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   raw    - asynchronous, bouncing button level (1 = pressed)
//   stable - debounced level; flips only after the synchronised input has
//            differed from it for DEBOUNCE_CYCLES consecutive cycles
module btn_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_out != stable_q) begin
            // The final differing cycle is the one that flips the level.
            if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Turns the four raw direction buttons into one move command per press,
// delivered over a valid/ready handshake. All buttons must be released
// before the next command can be raised.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   btnR, btnL, btnU, btnD   - raw button levels (1 = pressed)
//   cmd_valid                - a move command is pending
//   cmd_dir                  - move direction (00 R, 01 L, 10 U, 11 D)
//   cmd_ready                - consumer accepts when high with cmd_valid
//   btn_stable               - debounced levels {D,U,L,R}
module move_cmd_gen
    import five12_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnR,
    input  logic       btnL,
    input  logic       btnU,
    input  logic       btnD,
    output logic       cmd_valid,
    output logic [1:0] cmd_dir,
    input  logic       cmd_ready,
    output logic [3:0] btn_stable
);

    logic [3:0] btn_raw;
    assign btn_raw = {btnD, btnU, btnL, btnR};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn_raw[i]),
            .stable (btn_stable[i])
        );
    end

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (|btn_stable) begin
                    state_d = PEND;
                    dir_d   = prio_dir(btn_stable);
                end
            end
            PEND: begin
                if (cmd_ready) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (btn_stable == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_R;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    assign cmd_valid = (state_q == PEND);
    assign cmd_dir   = dir_q;

endmodule
